// File: rtl/logic_fold_pkg.sv
// rtl/logic_fold_pkg.sv - shared encodings for the logic fold unit
package logic_fold_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic MODE_PAIR = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

endpackage

// File: rtl/logic_fold_unit_bitwise_op.sv
// rtl/logic_fold_unit_bitwise_op.sv - combinational AND/OR/XOR/NAND selector
module bitwise_op
    import logic_fold_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_fold_unit.sv
// rtl/logic_fold_unit.sv - registered pairwise/accumulate bitwise fold; LOGIC_FOLD_ZERO_FLAG_EN adds outZero
module logic_fold_unit
    import logic_fold_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       inOp,
    input  logic             inMode,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] outCount
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
    ,
    output logic             outZero
`endif
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;

    logic [WIDTH-1:0] fold_a;
    logic [WIDTH-1:0] fold_b;
    logic [1:0]       fold_op;
    logic [WIDTH-1:0] fold_y;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] emit_cnt;
    logic             accept;
    logic             pop;
    logic             emit;

    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady;
    assign pop     = outValid && outReady;
    assign cnt_inc = cnt + CNT_W'(1);

    // One operator serves both the first beat (inA op inB) and the fold (acc op inA).
    always_comb begin
        fold_a   = inA;
        fold_b   = inB;
        fold_op  = inOp;
        emit_cnt = CNT_W'(1);
        emit     = 1'b0;
        if (state == ACCUM) begin
            fold_a   = acc;
            fold_b   = inA;
            fold_op  = op_q;
            emit_cnt = cnt_inc;
            emit     = accept && (inLast || (cnt_inc == CNT_W'(MAX_BURST)));
        end else begin
            emit     = accept && ((inMode == MODE_PAIR) || inLast);
        end
    end

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .a  (fold_a),
        .b  (fold_b),
        .op (fold_op),
        .y  (fold_y)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_q     <= OP_AND;
            out      <= '0;
            outCount <= '0;
            outValid <= 1'b0;
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
            outZero  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                acc <= fold_y;
                if (state == IDLE) begin
                    cnt <= CNT_W'(1);
                    if (inMode == MODE_ACC) begin
                        op_q <= inOp;
                        if (!inLast) begin
                            state <= ACCUM;
                        end
                    end
                end else begin
                    cnt <= cnt_inc;
                    if (emit) begin
                        state <= IDLE;
                    end
                end
            end
            // A same-cycle emit overrides the pop, keeping throughput at one per cycle.
            if (emit) begin
                out      <= fold_y;
                outCount <= emit_cnt;
                outValid <= 1'b1;
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
                outZero  <= (fold_y == '0);
`endif
            end else if (pop) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_fold_unit.sv
// tb/tb_logic_fold_unit.sv - self-checking bench for logic_fold_unit
module tb_logic_fold_unit;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);

    logic             clk = 1'b0;
    logic             resetN;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [1:0]       inOp;
    logic             inMode;
    logic             inLast;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] out;
    logic [CNT_W-1:0] outCount;
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
    logic             outZero;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic_fold_unit #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inA      (inA),
        .inB      (inB),
        .inOp     (inOp),
        .inMode   (inMode),
        .inLast   (inLast),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .outCount (outCount)
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
        ,
        .outZero  (outZero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] apply(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Reference: a burst is remembered as its seed pair plus the list of later words,
    // and the result is computed as a left fold over that list when the burst closes.
    bit         m_valid;
    logic [7:0] m_out;
    int         m_cnt;
    bit         m_zero;
    bit         in_burst;
    logic [1:0] b_op;
    logic [7:0] b_seed_a, b_seed_b;
    logic [7:0] b_words[$];

    always @(negedge resetN) begin
        m_valid = 0; m_out = 0; m_cnt = 0; m_zero = 0;
        in_burst = 0; b_words.delete();
    end

    always @(posedge clk) begin
        if (resetN) begin
            bit         ready, pop, emit;
            logic [7:0] res;
            int         n;
            ready = !m_valid || outReady;
            pop   = m_valid && outReady;
            emit  = 0;
            res   = 0;
            n     = 0;
            if (inValid && ready) begin
                if (!in_burst) begin
                    if (inMode == 1'b0 || inLast) begin
                        res = apply(inOp, inA, inB); n = 1; emit = 1;
                    end else begin
                        in_burst = 1; b_op = inOp; b_seed_a = inA; b_seed_b = inB;
                        b_words.delete();
                    end
                end else begin
                    b_words.push_back(inA);
                    if (inLast || b_words.size() + 1 == MAX_BURST) begin
                        res = apply(b_op, b_seed_a, b_seed_b);
                        foreach (b_words[i]) res = apply(b_op, res, b_words[i]);
                        n = b_words.size() + 1;
                        emit = 1; in_burst = 0;
                    end
                end
            end
            if (emit) begin
                m_valid = 1; m_out = res; m_cnt = n; m_zero = (res == 0);
            end else if (pop) begin
                m_valid = 0;
            end
        end
    end

    int pops[$];

    always @(negedge clk) begin
        if (resetN && started) begin
            check("inReady", int'(inReady), int'(!m_valid || outReady));
            check("outValid", int'(outValid), int'(m_valid));
            check("out", int'(out), int'(m_out));
            check("outCount", int'(outCount), m_cnt);
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
            check("outZero", int'(outZero), int'(m_zero));
`endif
            if (outValid && outReady) pops.push_back(int'(out) * 256 + int'(outCount));
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic mode, input logic last);
        int guard;
        inA = a; inB = b; inOp = op; inMode = mode; inLast = last; inValid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!inReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!inReady) begin
            errors++;
            checks++;
            $display("FAIL send_timeout actual %0d expected %0d", guard, 0);
        end
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    int exp_pops[$] = '{'hC001, 'h3401, 'h3C03, 'hFF01, 'h2601,
                        'hFF04, 'hFF02, 'h0702, 'h0001, 'hFF01};

    initial begin
        resetN = 0; inValid = 0; inA = 0; inB = 0; inOp = 0; inMode = 0; inLast = 0;
        outReady = 1;
        repeat (2) @(posedge clk);
        #2 resetN = 1;
        started = 1;
        #1;
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(outValid), 0);
        check("rst_count", int'(outCount), 0);
        check("rst_ready", int'(inReady), 1);

        send(8'hC3, 8'hF0, 2'b00, 1'b0, 1'b0);
        send(8'h34, 8'h76, 2'b00, 1'b0, 1'b0);

        send(8'h0F, 8'hF0, 2'b10, 1'b1, 1'b0);
        send(8'h3C, 8'h00, 2'b00, 1'b0, 1'b0);
        #1 check("acc_no_early_valid", int'(outValid), 0);
        send(8'hFF, 8'h00, 2'b00, 1'b0, 1'b1);
        #1 check("acc_xor_out", int'(out), 'h3C);

        // Backpressure: result must hold while the next beat waits.
        @(posedge clk); #1 outReady = 0;
        send(8'hAA, 8'h55, 2'b01, 1'b0, 1'b0);
        inA = 8'h12; inB = 8'h34; inOp = 2'b10; inMode = 0; inLast = 0; inValid = 1;
        repeat (3) @(negedge clk);
        #1;
        check("bp_held_out", int'(out), 'hFF);
        check("bp_ready_low", int'(inReady), 0);
        @(posedge clk); #1 outReady = 1;
        send(8'h12, 8'h34, 2'b10, 1'b0, 1'b0);

        send(8'hFF, 8'hFF, 2'b00, 1'b1, 1'b0);
        send(8'hFF, 8'h00, 2'b01, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 2'b01, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 2'b01, 1'b0, 1'b0);
        #1 check("max_burst_count", int'(outCount), 4);
        send(8'hFF, 8'hFF, 2'b00, 1'b1, 1'b0);
        send(8'hFF, 8'h00, 2'b00, 1'b0, 1'b1);

        send(8'h80, 8'h40, 2'b01, 1'b1, 1'b0);
        send(8'h20, 8'h00, 2'b01, 1'b0, 1'b0);
        #2 resetN = 0;
        #1;
        check("arst_valid", int'(outValid), 0);
        check("arst_out", int'(out), 0);
        @(posedge clk); #2 resetN = 1;
        send(8'h01, 8'h02, 2'b01, 1'b1, 1'b0);
        send(8'h04, 8'h00, 2'b00, 1'b0, 1'b1);
        #1 check("fresh_seed_out", int'(out), 'h07);

        send(8'hAA, 8'h55, 2'b00, 1'b0, 1'b0);
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
        #1 check("zero_flag_set", int'(outZero), 1);
`endif
        send(8'hAA, 8'h55, 2'b11, 1'b0, 1'b0);
`ifdef LOGIC_FOLD_ZERO_FLAG_EN
        #1 check("zero_flag_clear", int'(outZero), 0);
`endif
        repeat (3) @(posedge clk);

        check("pop_total", pops.size(), exp_pops.size());
        foreach (exp_pops[i]) begin
            if (i < pops.size()) check($sformatf("pop%0d", i), pops[i], exp_pops[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
